semaforo_ctrl: RTL



---
 rtl/semaforo_ctrl_pkg.sv | 22 ++
 rtl/semaforo_rr_sel.sv | 52 +++++
 rtl/semaforo_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/semaforo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// semaforo_ctrl_pkg
// Definitions shared by the traffic-light controller RTL and its bench.
//   estado_e : FSM state encoding (also driven out on the estado port)
//   max_t    : helper used to size the phase counter from the timing parameters
// -----------------------------------------------------------------------------
package semaforo_ctrl_pkg;

  localparam int ESTADO_W = 2;

  typedef enum logic [ESTADO_W-1:0] {
    ST_VERMELHO_TOTAL = 2'd0,
    ST_VERDE          = 2'd1,
    ST_AMARELO        = 2'd2,
    ST_PISCANTE       = 2'd3
  } estado_e;

  function automatic int max_t(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/semaforo_rr_sel.sv
// -----------------------------------------------------------------------------
// semaforo_rr_sel
// Combinational round-robin pick of the next approach to serve.
//   pend_i  : sticky request vector, one bit per approach
//   cur_i   : approach currently owning the phase
//   prox_o  : first pending approach found scanning cur+1, cur+2, ... (mod N)
//   valid_o : some approach other than cur_i is pending
// The current approach itself is never a candidate.
// -----------------------------------------------------------------------------
module semaforo_rr_sel #(
  parameter int N_VIAS = 2
) (
  input  logic [N_VIAS-1:0]         pend_i,
  input  logic [$clog2(N_VIAS)-1:0] cur_i,
  output logic [$clog2(N_VIAS)-1:0] prox_o,
  output logic                      valid_o
);

  localparam int IDX_W = $clog2(N_VIAS);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_VIAS) s = s - N_VIAS;
    return IDX_W'(s);
  endfunction

  // cand[k] is the request of the approach k positions after cur_i
  logic [N_VIAS-1:1] cand;
  logic [IDX_W-1:0]  cand_idx [N_VIAS-1:1];

  genvar gi;
  generate
    for (gi = 1; gi < N_VIAS; gi++) begin : g_cand
      assign cand_idx[gi] = wrap_idx(cur_i, gi);
      assign cand[gi]     = pend_i[cand_idx[gi]];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest pending approach wins.
  always_comb begin
    prox_o  = cur_i;
    valid_o = 1'b0;
    for (int k = N_VIAS - 1; k >= 1; k--) begin
      if (cand[k]) begin
        prox_o  = cand_idx[k];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/semaforo_ctrl.sv
// -----------------------------------------------------------------------------
// semaforo_ctrl
// Round-robin traffic-light controller for N_VIAS approaches with timed
// green / yellow / all-red phases, min/max green with gap-out, and a
// flashing-yellow maintenance mode.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   sensor    : vehicle present per approach (level)
//   pisca     : maintenance request, flashing yellow on all approaches
//   verde     : green lamp per approach
//   amarelo   : yellow lamp per approach
//   vermelho  : red lamp per approach
//   via_ativa : approach owning the current phase
//   estado    : current FSM state
// Lamps are decoded from registered state only; sensors never reach the
// lamps combinationally.
// -----------------------------------------------------------------------------
module semaforo_ctrl
  import semaforo_ctrl_pkg::*;
#(
  parameter int N_VIAS      = 2,
  parameter int T_VERDE_MIN = 4,
  parameter int T_VERDE_MAX = 8,
  parameter int T_AMARELO   = 2,
  parameter int T_VERMELHO  = 1,
  parameter int T_PISCA     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_VIAS-1:0]         sensor,
  input  logic                      pisca,
  output logic [N_VIAS-1:0]         verde,
  output logic [N_VIAS-1:0]         amarelo,
  output logic [N_VIAS-1:0]         vermelho,
  output logic [$clog2(N_VIAS)-1:0] via_ativa,
  output logic [1:0]                estado
);

  localparam int IDX_W = $clog2(N_VIAS);
  localparam int T_MAX = max_t(max_t(max_t(T_VERDE_MIN, T_VERDE_MAX),
                                     max_t(T_AMARELO, T_VERMELHO)), T_PISCA);
  localparam int CNT_W = $clog2(T_MAX) + 1;

  localparam logic [CNT_W-1:0] C_VERM_END  = CNT_W'(T_VERMELHO - 1);
  localparam logic [CNT_W-1:0] C_AMAR_END  = CNT_W'(T_AMARELO - 1);
  localparam logic [CNT_W-1:0] C_PISCA_END = CNT_W'(T_PISCA - 1);
  localparam logic [CNT_W-1:0] C_VMIN_END  = CNT_W'(T_VERDE_MIN - 1);
  localparam logic [CNT_W-1:0] C_VMAX_END  = CNT_W'(T_VERDE_MAX - 1);
  localparam logic [CNT_W-1:0] C_SAT       = {CNT_W{1'b1}};

  generate
    if (N_VIAS < 2 || T_VERDE_MIN < 1 || T_VERDE_MAX < T_VERDE_MIN ||
        T_AMARELO < 1 || T_VERMELHO < 1 || T_PISCA < 1) begin : g_param_check
      $error("semaforo_ctrl: illegal parameter set");
    end
  endgenerate

  estado_e           estado_q, estado_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [IDX_W-1:0]  prox_q, prox_d;
  logic [N_VIAS-1:0] pend_q, pend_d;
  logic              flash_q, flash_d;

  logic [N_VIAS-1:0] pend_set;
  logic [IDX_W-1:0]  rr_prox;
  logic              outro;

  // The approach that is green does not latch its own request: it is
  // being served right now.
  genvar gi;
  generate
    for (gi = 0; gi < N_VIAS; gi++) begin : g_pend_set
      assign pend_set[gi] = sensor[gi] &&
                            !((estado_q == ST_VERDE) && (cur_q == IDX_W'(gi)));
    end
  endgenerate

  semaforo_rr_sel #(
    .N_VIAS (N_VIAS)
  ) u_rr_sel (
    .pend_i  (pend_q),
    .cur_i   (cur_q),
    .prox_o  (rr_prox),
    .valid_o (outro)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= ST_VERMELHO_TOTAL;
      cnt_q    <= '0;
      cur_q    <= '0;
      prox_q   <= '0;
      pend_q   <= '0;
      flash_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      prox_q   <= prox_d;
      pend_q   <= pend_d;
      flash_q  <= flash_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    prox_d   = prox_q;
    flash_d  = flash_q;
    pend_d   = pend_q | pend_set;

    if (pisca && (estado_q != ST_PISCANTE)) begin
      // Maintenance pre-empts any phase; lamps start in the "on" half.
      estado_d = ST_PISCANTE;
      cnt_d    = '0;
      flash_d  = 1'b1;
    end else begin
      unique case (estado_q)
        ST_VERMELHO_TOTAL: begin
          if (cnt_q == C_VERM_END) begin
            estado_d       = ST_VERDE;
            cnt_d          = '0;
            cur_d          = prox_q;
            // Clearing after the set above makes clear win on a collision.
            pend_d[prox_q] = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_VERDE: begin
          // Gap-out once min green is served and the current approach is
          // empty; force-off at max green if it keeps demanding.
          if (outro && (cnt_q >= C_VMIN_END) &&
              (!sensor[cur_q] || (cnt_q >= C_VMAX_END))) begin
            estado_d = ST_AMARELO;
            cnt_d    = '0;
            prox_d   = rr_prox;
          end else if (cnt_q != C_SAT) begin
            // Green may rest forever; hold the counter instead of wrapping.
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_AMARELO: begin
          if (cnt_q == C_AMAR_END) begin
            estado_d = ST_VERMELHO_TOTAL;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_PISCANTE: begin
          if (!pisca) begin
            // Leaving maintenance always restarts service at approach 0.
            estado_d = ST_VERMELHO_TOTAL;
            cnt_d    = '0;
            prox_d   = '0;
          end else if (cnt_q == C_PISCA_END) begin
            cnt_d   = '0;
            flash_d = ~flash_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          estado_d = ST_VERMELHO_TOTAL;
          cnt_d    = '0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    verde    = '0;
    amarelo  = '0;
    vermelho = '1;
    unique case (estado_q)
      ST_VERDE: begin
        verde[cur_q]    = 1'b1;
        vermelho[cur_q] = 1'b0;
      end
      ST_AMARELO: begin
        amarelo[cur_q]  = 1'b1;
        vermelho[cur_q] = 1'b0;
      end
      ST_PISCANTE: begin
        vermelho = '0;
        amarelo  = {N_VIAS{flash_q}};
      end
      default: begin
      end
    endcase
  end

  assign via_ativa = cur_q;
  assign estado    = estado_q;

endmodule
